count_monitor: RTL
==================

# count_monitor

Sequence checker for the 3-bit synchronous counter's `q` output: it samples the count stream, locks onto the expected increment-by-one sequence with wrap-around, and flags, counts and recovers from sequence errors. It sits beside the counter on the same `clk`/`rst`. It is the consuming end of the counter's output interface, used both in-system as a health monitor and in benches as a self-checking scoreboard.

## Interface

Parameters:
- `WIDTH`, default 3: count width; the sequence wraps at 2^WIDTH-1 -> 0.
- `ERR_CNT_W`, default 8: error counter width.
- `LOCK_THRESH`, default 4: consecutive in-sequence samples needed to lock. The seed sample counts. Legal values are >= 2.
- `UNLOCK_THRESH`, default 2: consecutive mismatches while locked that drop lock. Legal values are >= 1.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `q_in`  in  WIDTH  count value under check.
- `sample_en`  in  1  `q_in` is valid this cycle.
- `err_clr`  in  1  clears `err_count`.
- `locked`  out  1  monitor is in LOCKED.
- `expected`  out  WIDTH  next value the monitor predicts.
- `err_pulse`  out  1  one-cycle pulse per mismatch while locked.
- `wrap_pulse`  out  1  one-cycle pulse when a locked, matching sample equals 2^WIDTH-1.
- `err_count`  out  ERR_CNT_W  saturating mismatch count.

## Operation

- All outputs are registered. Reset value of every output is 0. Internal `good_run`, `bad_run` and state also reset (state to IDLE).
- `rst` has priority over every other input.
- A sample is taken on a rising edge where `sample_en`=1.
- With `sample_en`=0 there is no state, run-counter or `expected` change. `err_pulse` and `wrap_pulse` are 0.
- All `+1` arithmetic is modulo 2^WIDTH.

IDLE, on a sample:
- `expected` <= `q_in`+1
- `good_run` <= 1
- go to ACQUIRE.

ACQUIRE, on a sample:
- Match (`q_in`==`expected`): `good_run`++. If the new `good_run` == `LOCK_THRESH`, go to LOCKED and set `locked`=1.
- Mismatch: `good_run` <= 1. No `err_pulse`, no `err_count` change.
- In both cases `expected` <= `q_in`+1.

LOCKED, on a sample:
- Match: `expected` <= `expected`+1, `bad_run` <= 0. Assert `wrap_pulse` if `q_in` == 2^WIDTH-1.
- Mismatch: `err_pulse`=1, `err_count` saturating +1, `bad_run`++.
  - If the new `bad_run` == `UNLOCK_THRESH`: go to ACQUIRE, `locked` <= 0, `bad_run` <= 0, `good_run` <= 1, `expected` <= `q_in`+1 (reseed).
  - Otherwise: `expected` <= `expected`+1 (flywheel). The erroneous value is not used.

`err_count`:
- Saturates at 2^ERR_CNT_W-1.
- `err_clr` forces it to 0. If `err_clr` coincides with a mismatch, the clear wins and the result is 0.
- `err_clr` does not affect state, `locked` or the run counters.

## Timing

- Latency: every output reflects a sample one cycle after the sampling edge, i.e. it is visible after the same edge that captures `q_in`.
- Lock latency: `locked` rises after the `LOCK_THRESH`-th consecutive good sample, counted from the first post-reset sample.
- Unlock: `locked` falls together with the `err_pulse` of the `UNLOCK_THRESH`-th consecutive mismatch.
- `err_pulse` and `wrap_pulse` are never high for two consecutive cycles unless samples arrive on consecutive cycles. They are mutually exclusive.
- Reset mid-operation: in the cycle after `rst` is sampled high, every output is 0 and the state is IDLE, regardless of `sample_en`.
- Back-to-back samples every cycle are supported. There is no throughput limit.

## Test plan

1. Reset for 2 cycles, then drive `q_in` = 0,1,…,7,0,1 with `sample_en`=1 every cycle (defaults) -> `locked`=1 after the sample q=3. `wrap_pulse` for exactly one cycle after the sample q=7. `err_count`=0 throughout. `expected`=2 after the final sample.
2. Once locked, drive …0,1,5,3,4 -> a single `err_pulse` after the 5, `err_count`=1, `locked` stays 1, `expected`=3 after the 5, no further pulses.
3. Once locked, drive …1,6,6 then 6,7,0,1 -> `err_pulse` on both 6s, `locked`=0 after the second 6, `err_count`=2. `locked` returns to 1 after the sample q=1 (seed 6, then 7, 0, 1 = 4 good).
4. Clean sequence with `sample_en` low on random gaps of 1–5 cycles (`q_in` driven with garbage during gaps) -> identical `locked`/`wrap_pulse` sequence to test 1 in sample order, `err_count`=0.
5. `ERR_CNT_W`=2, `UNLOCK_THRESH`=8, locked, then 5 mismatches -> `err_count` sticks at 3. Then `err_clr` on the same cycle as a mismatch -> `err_count`=0, `err_pulse`=1.
6. Locked and sampling, assert `rst` for one cycle -> next cycle all outputs 0. The following sample at q=5 reseeds `expected`=6, with no `err_pulse`.

Source files
------------

// File: rtl/count_monitor_if.sv
// Count-stream interface between a counter (master) and its sequence monitor (slave).
// The master side drives the sampled count and control; the slave side returns status.
interface count_monitor_if #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned ERR_CNT_W = 8
);

  logic [WIDTH-1:0]     q_in;
  logic                 sample_en;
  logic                 err_clr;
  logic                 locked;
  logic [WIDTH-1:0]     expected;
  logic                 err_pulse;
  logic                 wrap_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output q_in,
    output sample_en,
    output err_clr,
    input  locked,
    input  expected,
    input  err_pulse,
    input  wrap_pulse,
    input  err_count
  );

  modport slave (
    input  q_in,
    input  sample_en,
    input  err_clr,
    output locked,
    output expected,
    output err_pulse,
    output wrap_pulse,
    output err_count
  );

endinterface

// File: rtl/count_monitor.sv
// Sequence checker for an increment-by-one wrapping counter. Seeds on the first sample,
// locks after LOCK_THRESH consecutive in-sequence samples, flywheels through isolated errors
// while locked and reseeds after UNLOCK_THRESH consecutive mismatches.
module count_monitor #(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned ERR_CNT_W     = 8,
  parameter int unsigned LOCK_THRESH   = 4,
  parameter int unsigned UNLOCK_THRESH = 2
) (
  input logic               clk,
  input logic               rst,
  count_monitor_if.slave    mon
);

  // Run counters only need to reach their thresholds.
  localparam int unsigned GoodW = $clog2(LOCK_THRESH + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_THRESH + 1);

  localparam logic [GoodW-1:0]     LockThr   = GoodW'(LOCK_THRESH);
  localparam logic [BadW-1:0]      UnlockThr = BadW'(UNLOCK_THRESH);
  localparam logic [WIDTH-1:0]     WrapVal   = '1;
  localparam logic [ERR_CNT_W-1:0] ErrMax    = '1;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StLocked
  } state_e;

  state_e               state_q, state_d;
  logic [GoodW-1:0]     good_run_q, good_run_d;
  logic [BadW-1:0]      bad_run_q, bad_run_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 match;
  logic [WIDTH-1:0]     q_plus1;
  logic [WIDTH-1:0]     exp_plus1;
  logic [GoodW-1:0]     good_inc;
  logic [BadW-1:0]      bad_inc;

  assign match     = (mon.q_in == expected_q);
  assign q_plus1   = mon.q_in + WIDTH'(1);
  assign exp_plus1 = expected_q + WIDTH'(1);
  assign good_inc  = good_run_q + GoodW'(1);
  assign bad_inc   = bad_run_q + BadW'(1);

  // Next-state, run counters, prediction and status outputs.
  always_comb begin
    state_d      = state_q;
    good_run_d   = good_run_q;
    bad_run_d    = bad_run_q;
    expected_d   = expected_q;
    locked_d     = locked_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_count_d  = err_count_q;

    if (mon.sample_en) begin
      unique case (state_q)
        StIdle: begin
          expected_d = q_plus1;
          good_run_d = GoodW'(1);
          state_d    = StAcquire;
        end

        StAcquire: begin
          // Acquisition always re-predicts from the observed value.
          expected_d = q_plus1;
          if (match) begin
            good_run_d = good_inc;
            if (good_inc == LockThr) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end else begin
            good_run_d = GoodW'(1);
          end
        end

        StLocked: begin
          if (match) begin
            expected_d   = exp_plus1;
            bad_run_d    = '0;
            wrap_pulse_d = (mon.q_in == WrapVal);
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != ErrMax) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
            if (bad_inc == UnlockThr) begin
              state_d    = StAcquire;
              locked_d   = 1'b0;
              bad_run_d  = '0;
              good_run_d = GoodW'(1);
              expected_d = q_plus1;
            end else begin
              // Flywheel: keep predicting from the locked sequence, ignore the bad value.
              bad_run_d  = bad_inc;
              expected_d = exp_plus1;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Clear beats a simultaneous increment.
    if (mon.err_clr) begin
      err_count_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      good_run_q   <= '0;
      bad_run_q    <= '0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      good_run_q   <= good_run_d;
      bad_run_q    <= bad_run_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

  assign mon.locked     = locked_q;
  assign mon.expected   = expected_q;
  assign mon.err_pulse  = err_pulse_q;
  assign mon.wrap_pulse = wrap_pulse_q;
  assign mon.err_count  = err_count_q;

endmodule
